// File: rtl/fft_ctrl_in.sv
`default_nettype none
// ============================================================================
// Module   : fft_ctrl_in
// Purpose  : Streams one frame of complex samples from a dual-port RAM into
//            the FFT core's Avalon-ST sink. Issues sop/eop/valid framing and
//            honours sink_ready through a credit-limited output FIFO.
// Revision : 1.0  initial release
// ============================================================================
module fft_ctrl_in #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATAIN_WIDTH  = 64,
  parameter int DATAOUT_WIDTH = 16,
  parameter int RD_LATENCY    = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic [ADDR_WIDTH:0]      nfft,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_WIDTH-1:0]    addr,
  output logic                     rden,
  input  logic [DATAIN_WIDTH-1:0]  datain,
  output logic                     sink_valid,
  input  logic                     sink_ready,
  output logic                     sink_sop,
  output logic                     sink_eop,
  output logic [DATAOUT_WIDTH-1:0] dataout_re,
  output logic [DATAOUT_WIDTH-1:0] dataout_im
);

  // FIFO holds every read that may be outstanding, so credits alone prevent overflow
  localparam int DEPTH = RD_LATENCY + 2;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW    = $clog2(DEPTH + 1);
  localparam int HALF  = DATAIN_WIDTH / 2;
  localparam logic [ADDR_WIDTH:0] C_MAX_N = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH:0]    len_q, len_d;
  logic [ADDR_WIDTH:0]    rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH:0]    out_cnt_q, out_cnt_d;
  logic [OW-1:0]          outst_q, outst_d;
  logic                   rden_q, rden_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [RD_LATENCY-1:0]  tag_q;

  logic [2*DATAOUT_WIDTH-1:0] fifo_mem_q [DEPTH];
  logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]              fifo_cnt_q, fifo_cnt_d;
  logic                       valid_q;

  logic                       w_handoff;
  logic                       w_push;
  logic                       w_issue;
  logic                       w_eop;
  logic [OW-1:0]              w_credit;
  logic [2*DATAOUT_WIDTH-1:0] w_wdata;
  logic                       w_unused_datain;

  assign w_handoff  = valid_q & sink_ready;
  assign w_push     = tag_q[RD_LATENCY-1];
  assign w_credit   = outst_q - OW'(w_handoff);
  assign w_eop      = valid_q & (out_cnt_q == (len_q - (ADDR_WIDTH+1)'(1)));
  assign w_wdata    = {datain[HALF+DATAOUT_WIDTH-1:HALF], datain[DATAOUT_WIDTH-1:0]};
  assign fifo_cnt_d = fifo_cnt_q + OW'(w_push) - OW'(w_handoff);
  // Only the low bits of each half reach the core; the rest is intentionally dropped
  assign w_unused_datain = ^datain;

  // Next-state, read-issue and credit accounting
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rd_cnt_d  = rd_cnt_q;
    out_cnt_d = out_cnt_q;
    outst_d   = outst_q;
    rden_d    = 1'b0;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    w_issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Read 0 issues on the accepting edge so rden is visible the next cycle
        if (START && (nfft != '0) && (nfft <= C_MAX_N)) begin
          state_d   = S_RUN;
          len_d     = nfft;
          rd_cnt_d  = (ADDR_WIDTH+1)'(1);
          out_cnt_d = '0;
          outst_d   = OW'(1);
          rden_d    = 1'b1;
          addr_d    = '0;
          busy_d    = 1'b1;
        end
      end
      S_RUN: begin
        // A handoff this cycle returns its credit in time for the next read
        w_issue = (rd_cnt_q < len_q) && (w_credit < OW'(DEPTH));
        if (w_issue) begin
          rden_d   = 1'b1;
          addr_d   = rd_cnt_q[ADDR_WIDTH-1:0];
          rd_cnt_d = rd_cnt_q + (ADDR_WIDTH+1)'(1);
        end
        outst_d = w_credit + OW'(w_issue);
        if (w_handoff) begin
          out_cnt_d = out_cnt_q + (ADDR_WIDTH+1)'(1);
          if (w_eop) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and counter registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      out_cnt_q <= '0;
      outst_q   <= '0;
      rden_q    <= 1'b0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rd_cnt_q  <= rd_cnt_d;
      out_cnt_q <= out_cnt_d;
      outst_q   <= outst_d;
      rden_q    <= rden_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Tag pipeline marks the cycle on which each issued read returns; reset drops in-flight reads
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tag_q <= '0;
    end else begin
      tag_q <= (tag_q << 1) | RD_LATENCY'(rden_q);
    end
  end

  // Output FIFO: push returning reads, pop on handoff
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      if (w_push) begin
        fifo_mem_q[wr_ptr_q] <= w_wdata;
        wr_ptr_q <= (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (w_handoff) begin
        rd_ptr_q <= (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
      end
      fifo_cnt_q <= fifo_cnt_d;
      valid_q    <= (fifo_cnt_d != '0);
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign addr       = addr_q;
  assign rden       = rden_q;
  assign sink_valid = valid_q;
  assign sink_sop   = valid_q & (out_cnt_q == '0);
  assign sink_eop   = w_eop;
  assign dataout_re = fifo_mem_q[rd_ptr_q][2*DATAOUT_WIDTH-1:DATAOUT_WIDTH];
  assign dataout_im = fifo_mem_q[rd_ptr_q][DATAOUT_WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fft_ctrl_in.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_ctrl_in
// Purpose  : Self-checking bench for fft_ctrl_in. A frame table drives a
//            generic frame runner; reset behaviour has hand-written sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_fft_ctrl_in;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [AW:0] nfft;
  logic        busy, done, rden;
  logic [AW-1:0] addr;
  logic [63:0] datain;
  logic        sink_valid, sink_ready, sink_sop, sink_eop;
  logic [15:0] dataout_re, dataout_im;

  int n_tests = 0;
  int n_fail  = 0;

  // RAM model: two-cycle read latency, RAM[i] = {16'h0, i, 16'h0, ~i}
  logic [63:0] mem [1024];
  logic [63:0] ram_s1;

  fft_ctrl_in dut (
    .CLK        (clk),
    .RST        (rst),
    .START      (start),
    .nfft       (nfft),
    .busy       (busy),
    .done       (done),
    .addr       (addr),
    .rden       (rden),
    .datain     (datain),
    .sink_valid (sink_valid),
    .sink_ready (sink_ready),
    .sink_sop   (sink_sop),
    .sink_eop   (sink_eop),
    .dataout_re (dataout_re),
    .dataout_im (dataout_im)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_s1 <= mem[addr];
    datain <= ram_s1;
  end

  // mode: 0 = ready always, 1 = ready 1,0,0,1 repeating, 2 = ready low for 20 cycles
  // sop/eop/done: expected first cycle (relative to START edge); 0 = not checked
  // rd20: expected rden pulses within the first 20 cycles; -1 = not checked
  // xstart: cycle at which a second START (with nfft=4) is pulsed; 0 = none
  typedef struct {
    int nfft;
    int mode;
    int accept;
    int sop;
    int eop;
    int dn;
    int rd20;
    int xstart;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int hand, rd_exp, issued, dones, sop_c, eop_c, done_c, rd20, max_out, cyc, budget;
    logic rdy, pv, pr, psop, peop;
    logic [15:0] pre, pim, eim;
    hand = 0; rd_exp = 0; issued = 0; dones = 0; rd20 = 0; max_out = 0;
    sop_c = -1; eop_c = -1; done_c = -1;
    pv = 1'b0; pr = 1'b1; pre = '0; pim = '0; psop = 1'b0; peop = 1'b0;
    nfft  = (AW+1)'(v.nfft);
    start = 1'b1;
    sink_ready = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    if (v.accept == 0) begin
      for (int i = 0; i < 8; i++) begin
        check("ignored_busy", busy, 0);
        check("ignored_rden", rden, 0);
        step();
      end
      return;
    end
    budget = 4 * v.nfft + 60;
    while (cyc <= budget) begin
      if (rden) begin
        check("addr", addr, rd_exp);
        rd_exp++;
        issued++;
        if (cyc <= 20) rd20++;
      end
      if (pv && !pr) begin
        check("stall_valid", sink_valid, 1);
        check("stall_re", dataout_re, pre);
        check("stall_im", dataout_im, pim);
        check("stall_sop", sink_sop, psop);
        check("stall_eop", sink_eop, peop);
      end
      case (v.mode)
        1:       rdy = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        2:       rdy = (cyc > 20);
        default: rdy = 1'b1;
      endcase
      sink_ready = rdy;
      if (issued - hand > max_out) max_out = issued - hand;
      if (sink_valid && sink_sop && sop_c < 0) sop_c = cyc;
      if (sink_valid && sink_eop && eop_c < 0) eop_c = cyc;
      if (sink_valid && rdy) begin
        eim = ~hand[15:0];
        check("data_re", dataout_re, hand[15:0]);
        check("data_im", dataout_im, eim);
        check("sop_flag", sink_sop, (hand == 0) ? 1 : 0);
        check("eop_flag", sink_eop, (hand == v.nfft - 1) ? 1 : 0);
        hand++;
      end
      if (done) begin
        dones++;
        if (done_c < 0) done_c = cyc;
        check("busy_at_done", busy, 0);
      end else if (dones == 0) begin
        check("busy_in_frame", busy, 1);
      end
      start = (v.xstart == cyc);
      if (v.xstart == cyc) nfft = (AW+1)'(4);
      if (dones > 0 && cyc >= done_c + 3) break;
      pv = sink_valid; pr = rdy; pre = dataout_re; pim = dataout_im;
      psop = sink_sop; peop = sink_eop;
      step();
      cyc++;
    end
    start = 1'b0;
    sink_ready = 1'b1;
    check("samples_out", hand, v.nfft);
    check("reads_issued", issued, v.nfft);
    check("done_count", dones, 1);
    check("sop_cycle", sop_c, v.sop);
    if (v.eop > 0) check("eop_cycle", eop_c, v.eop);
    if (v.dn > 0) check("done_cycle", done_c, v.dn);
    check("done_after_eop", done_c, eop_c + 1);
    check("max_outstanding_le4", (max_out <= 4) ? 1 : 0, 1);
    if (v.rd20 >= 0) check("rden_first20", rd20, v.rd20);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rden"}, rden, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_valid"}, sink_valid, 0);
    check({tag, "_sop"}, sink_sop, 0);
    check({tag, "_eop"}, sink_eop, 0);
    check({tag, "_re"}, dataout_re, 0);
    check({tag, "_im"}, dataout_im, 0);
  endtask

  initial begin
    int cnt;
    vec_t rv;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = {16'h0, 16'(i), 16'h0, ~16'(i)};
    end
    tbl[0] = '{8,    0, 1, 4, 11,   12,   8,  0};
    tbl[1] = '{16,   1, 1, 4, 33,   34,   -1, 0};
    tbl[2] = '{1,    0, 1, 4, 4,    5,    1,  0};
    tbl[3] = '{1024, 0, 1, 4, 1027, 1028, 20, 0};
    tbl[4] = '{0,    0, 0, 0, 0,    0,    -1, 0};
    tbl[5] = '{1025, 0, 0, 0, 0,    0,    -1, 0};
    tbl[6] = '{8,    0, 1, 4, 11,   12,   8,  3};
    tbl[7] = '{8,    2, 1, 4, 28,   29,   4,  0};

    rst = 1'b1; start = 1'b0; nfft = '0; sink_ready = 1'b1;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    for (int k = 0; k < 8; k++) begin
      run_vec(tbl[k]);
      step();
    end

    // Reset after the 5th handoff of a 32-sample frame, then replay it
    nfft = (AW+1)'(32);
    sink_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    cnt = 0;
    for (int c = 1; c < 40 && cnt < 5; c++) begin
      if (sink_valid && sink_ready) cnt++;
      step();
    end
    check("midframe_handoffs", cnt, 5);
    check("midframe_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    step();
    rst = 1'b0;
    step();
    rv = '{32, 0, 1, 4, 35, 36, 20, 0};
    run_vec(rv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
